// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, operand
// width, queued command layout and FSM state encoding.
package alu_pkg;

  localparam int unsigned OPND_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // A divide with a zero divisor is answered locally, never sent to the ALU.
  function automatic logic is_div_by_zero(input cmd_t cmd);
    return (cmd.opcode == OP_DIV) && (cmd.b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle of the ALU command sequencer.
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_opcode;
  logic [OPND_W-1:0] cmd_a;
  logic [OPND_W-1:0] cmd_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_opcode;
  logic [OPND_W-1:0] rsp_data;
  logic              rsp_error;
  logic              rsp_timeout;

  // Producer of commands / consumer of responses.
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_opcode, rsp_data, rsp_error, rsp_timeout
  );

  // The sequencer side.
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_opcode, rsp_data, rsp_error, rsp_timeout
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands. A push while full is dropped
// even when a pop happens in the same cycle (no bypass).
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands and issues them one at a time to an external ALU,
// returning one response per command (result, divide-by-zero or timeout).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  alu_cmd_sequencer_if.slave bus,
  output logic              alu_start,
  output logic [1:0]        alu_opcode,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  input  logic [OPND_W-1:0] alu_result,
  input  logic              alu_done,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  cmd_t              head;
  cmd_t              push_cmd;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              load_alu;
  logic              rsp_load;
  logic [1:0]        rsp_opcode_nxt;
  logic [OPND_W-1:0] rsp_data_nxt;
  logic              rsp_error_nxt;
  logic              rsp_timeout_nxt;
  logic [CNT_W-1:0]  wait_cnt;

  assign push_cmd      = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};
  assign push          = bus.cmd_valid & ~full;
  assign bus.cmd_ready = ~full;
  assign bus.rsp_valid = (state == S_RESP);
  assign alu_start     = (state == S_ISSUE);
  assign busy          = (state != S_IDLE) | ~empty;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, queue pop and response capture decisions.
  always_comb begin
    state_nxt       = state;
    pop             = 1'b0;
    load_alu        = 1'b0;
    rsp_load        = 1'b0;
    rsp_opcode_nxt  = alu_opcode;
    rsp_data_nxt    = '0;
    rsp_error_nxt   = 1'b0;
    rsp_timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_div_by_zero(head)) begin
            state_nxt      = S_RESP;
            rsp_load       = 1'b1;
            rsp_opcode_nxt = head.opcode;
            rsp_error_nxt  = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
            load_alu  = 1'b1;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          state_nxt    = S_RESP;
          rsp_load     = 1'b1;
          rsp_data_nxt = alu_result;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt       = S_RESP;
          rsp_load        = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // WAIT cycle counter: zero outside WAIT, counts cycles spent in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
    else                       wait_cnt <= '0;
  end

  // ALU operand registers, held from ISSUE until the next command loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (load_alu) begin
      alu_opcode <= head.opcode;
      alu_a      <= head.a;
      alu_b      <= head.b;
    end
  end

  // Response registers, loaded on entry to RESP and held while it waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rsp_opcode  <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_error   <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else if (rsp_load) begin
      bus.rsp_opcode  <= rsp_opcode_nxt;
      bus.rsp_data    <= rsp_data_nxt;
      bus.rsp_error   <= rsp_error_nxt;
      bus.rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  queue can accept; transfer when cmd_valid&cmd_ready at rising edge.
REQ-007 cmd_opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 cmd_a, cmd_b  input  8 each  operands.
REQ-009 alu_start  output  1  one-cycle start pulse to ALU.
REQ-010 alu_opcode, alu_a, alu_b  output  2/8/8  operands driven to ALU inbus_a/inbus_b.
REQ-011 alu_result  input  8  ALU outbus.
REQ-012 alu_done  input  1  ALU completion.
REQ-013 rsp_valid  output  1  response present; rsp_ready  input  1  downstream accepts.
REQ-014 rsp_opcode  output  2, rsp_data  output  8, rsp_error  output  1 (divide by zero), rsp_timeout  output  1.
REQ-015 busy  output  1  high when FSM not IDLE or queue non-empty.

Function
REQ-016 Queue SHALL be FIFO order; cmd_ready = not full; no bypass, so push is refused when full even if a pop occurs same cycle.
REQ-017 FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE -> ISSUE when queue non-empty; head popped and latched into alu_opcode/alu_a/alu_b on that transition.
REQ-019 Exception: head with opcode DIV and b=0 SHALL be popped and go IDLE -> RESP with rsp_error=1, rsp_data=0, no alu_start.
REQ-020 ISSUE lasts exactly one cycle with alu_start=1; alu_start SHALL be 0 in every other state.
REQ-021 alu_opcode/alu_a/alu_b SHALL stay stable from ISSUE until leaving WAIT.
REQ-022 WAIT: alu_done is sampled only in WAIT; first cycle with alu_done=1 captures alu_result into rsp_data and -> RESP.
REQ-023 WAIT counter starts at 0 on entry, increments each WAIT cycle; at TIMEOUT_CYCLES without done -> RESP with rsp_timeout=1, rsp_data=0.
REQ-024 alu_done arriving outside WAIT SHALL be ignored.
REQ-025 RESP: rsp_valid=1, rsp_* stable until rsp_ready=1 at a rising edge, then -> IDLE.
REQ-026 rsp_valid SHALL be 1 only in RESP; rsp_error and rsp_timeout never both 1.
REQ-027 Latency: command pushed into empty queue at edge k with FSM IDLE -> alu_start high in the cycle after edge k+1.
REQ-028 Throughput: at most one command in flight; back-to-back commands separated by RESP->IDLE->ISSUE.
REQ-029 cmd_valid held while cmd_ready=0 SHALL not be lost or duplicated.

Reset
REQ-030 reset low SHALL immediately force IDLE, empty queue, counter 0.
REQ-031 Reset values: cmd_ready=1, alu_start=0, alu_opcode=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_opcode=0, rsp_data=0, rsp_error=0, rsp_timeout=0, busy=0.
REQ-032 Reset during WAIT or RESP SHALL discard the in-flight command with no response.

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, FSM state encoding, operand width 8.
REQ-034 Queue SHALL be sub-module alu_cmd_fifo (parameterised depth, width 18, push/pop, full/empty).

Verification
REQ-035 Push {ADD,15,10}, ALU model done after 3 cycles -> one alu_start, rsp_data=25, error=0, timeout=0.
REQ-036 Push SUB 25-10, MUL 5*6, DIV 30/5 back-to-back -> responses in order 15, 30, 6; exactly three alu_start pulses.
REQ-037 Push {DIV,30,0} -> no alu_start, rsp_valid with rsp_error=1, rsp_data=0.
REQ-038 ALU model never asserts done -> rsp_timeout=1 after 64 WAIT cycles; later done ignored; next command completes normally.
REQ-039 Hold rsp_ready=0, push 5 commands -> cmd_ready drops after queue full (4 queued + 1 in RESP), no loss; release -> all 5 responses in order.
REQ-040 Assert reset during WAIT -> all outputs reach reset values immediately, no response emitted, next command after reset works.
